// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Optional feature macro used by the top: SERIAL_SUB_SIGNED_OVF_EN.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_t;

   localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_sub_bit.sv
// One-bit full subtractor: d = x - y - bin, bnext is the borrow out.
module serial_sub_bit (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bnext
);

   always_comb begin
      d     = x ^ y ^ bin;
      bnext = (~x & y) | (~(x ^ y) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock through one full-subtractor cell.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);

   sub_state_t       state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d;
   logic [WIDTH-1:0] rb_q, rb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             d_bit, b_next;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             ovf_q, ovf_d;
`endif

   serial_sub_bit u_bit (
      .x     (ra_q[0]),
      .y     (rb_q[0]),
      .bin   (br_q),
      .d     (d_bit),
      .bnext (b_next)
   );

   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               br_d    = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
`endif
            end
         end
         SHIFT: begin
            diff_d = {d_bit, diff_q[WIDTH-1:1]};
            ra_d   = ra_q >> 1;
            rb_d   = rb_q >> 1;
            br_d   = b_next;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               bout_d  = b_next;
               done_d  = 1'b1;
               state_d = DONE;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
               // d_bit is the final difference MSB on this cycle
               ovf_d   = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
`endif
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a, b;
   logic       busy, done, bout;
   logic [7:0] diff;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic       ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept on the next edge, scramble a/b, then wait (bounded) for done.
   task automatic do_op(input logic [7:0] av, input logic [7:0] bv, output int lat);
      a = av;
      b = bv;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = ~av;
      b = ~bv;
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   int lat;
   int pulses;
   logic [7:0] ra, rb;

   initial begin
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_diff", diff, 0);
      check("reset_bout", bout, 0);

      // 5 - 3
      do_op(8'h05, 8'h03, lat);
      check("lat_5m3", lat, 8);
      check("diff_5m3", diff, 8'h02);
      check("bout_5m3", bout, 0);
      tick();
      check("done_drop", done, 0);
      check("busy_drop", busy, 0);
      check("diff_hold", diff, 8'h02);

      do_op(8'h03, 8'h05, lat);
      check("diff_3m5", diff, 8'hFE);
      check("bout_3m5", bout, 1);
      tick();
      do_op(8'hFF, 8'hFF, lat);
      check("diff_ffmff", diff, 8'h00);
      check("bout_ffmff", bout, 0);
      tick();
      do_op(8'h00, 8'h00, lat);
      check("diff_0m0", diff, 8'h00);
      check("bout_0m0", bout, 0);
      tick();
      do_op(8'h00, 8'h01, lat);
      check("diff_0m1", diff, 8'hFF);
      check("bout_0m1", bout, 1);
      tick();

`ifdef SERIAL_SUB_SIGNED_OVF_EN
      do_op(8'h80, 8'h01, lat);
      check("diff_80m1", diff, 8'h7F);
      check("ovf_80m1", ovf, 1);
      tick();
      do_op(8'h10, 8'h01, lat);
      check("diff_10m1", diff, 8'h0F);
      check("ovf_10m1", ovf, 0);
      tick();
`endif

      // start held high through SHIFT and DONE
      a = 8'h0A;
      b = 8'h01;
      start = 1'b1;
      tick();
      check("held_busy_e0", busy, 1);
      pulses = 0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (done) begin
            pulses++;
            check("held_diff", diff, 8'h09);
         end
      end
      check("held_pulses", pulses, 1);
      check("held_busy_e9", busy, 0);
      tick();
      check("held_reaccept_e10", busy, 1);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      check("held_second_diff", diff, 8'h09);
      tick();

      // back-to-back: start raised in the cycle after done
      do_op(8'h20, 8'h01, lat);
      check("b2b_first", diff, 8'h1F);
      tick();
      a = 8'h0A;
      b = 8'h01;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("b2b_accept", busy, 1);
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      check("b2b_lat", lat, 8);
      check("b2b_second", diff, 8'h09);
      tick();

      // reset during shift cycle 4
      a = 8'h0F;
      b = 8'h01;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_diff", diff, 0);
      check("rst_mid_bout", bout, 0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) pulses++;
         tick();
      end
      check("rst_mid_no_done", pulses, 0);
      do_op(8'h0F, 8'h01, lat);
      check("rst_after_diff", diff, 8'h0E);
      tick();

      // random pairs
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         do_op(ra, rb, lat);
         check("rand_diff", diff, 8'(ra - rb));
         check("rand_bout", bout, (ra < rb) ? 1 : 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
